// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
//   Shares a single DATAWIDTH-bit multiplier between NREQ requesters using
//   round-robin arbitration. The winning requester's operands are registered,
//   multiplied, and the low DATAWIDTH bits of the product are held together
//   with the requester ID until the consumer accepts them.
//
// Ports
//   Clk        in   clock, all state changes on the rising edge
//   Rst        in   synchronous reset, active-low
//   req        in   per-requester request, held until its gnt bit is seen
//   a_bus      in   packed operand A, slice i = [i*DATAWIDTH +: DATAWIDTH]
//   b_bus      in   packed operand B, same packing
//   gnt        out  one-hot grant pulse; that requester's operands are captured
//   busy       out  high whenever the unit is not idle
//   prod       out  registered product (low DATAWIDTH bits of a*b)
//   prod_id    out  requester index owning prod
//   prod_valid out  prod/prod_id valid, held until prod_ready
//   prod_ready in   consumer accepts prod when prod_valid & prod_ready
module mul_share_arbiter #(
  parameter int DATAWIDTH = 64,
  parameter int NREQ      = 4,
  parameter int IDW       = 2
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DATAWIDTH-1:0] a_bus,
  input  logic [NREQ*DATAWIDTH-1:0] b_bus,
  output logic [NREQ-1:0]           gnt,
  output logic                      busy,
  output logic [DATAWIDTH-1:0]      prod,
  output logic [IDW-1:0]            prod_id,
  output logic                      prod_valid,
  input  logic                      prod_ready
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state;
  state_t               state_next;
  logic [IDW-1:0]       rr_ptr;
  logic [IDW-1:0]       win_id;
  logic [IDW-1:0]       rr_next;
  logic [31:0]          scan_idx;
  logic [DATAWIDTH-1:0] a_r;
  logic [DATAWIDTH-1:0] b_r;
  logic [IDW-1:0]       id_r;

  // Round-robin search: scanning offsets from the far end down to zero lets
  // the lowest offset (closest to rr_ptr) overwrite any later candidate.
  always_comb begin
    win_id   = '0;
    scan_idx = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      scan_idx = 32'((int'(rr_ptr) + off) % NREQ);
      if (req[scan_idx]) begin
        win_id = scan_idx[IDW-1:0];
      end
    end
  end

  // Pointer moves to the slot just past the winner, wrapping at NREQ.
  assign rr_next = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant is only offered from IDLE and is suppressed while reset is held so
  // that no requester believes its operands were taken.
  always_comb begin
    state_next = state;
    gnt        = '0;
    case (state)
      IDLE: begin
        if (req != '0) begin
          state_next = CALC;
          if (Rst) begin
            gnt[win_id] = 1'b1;
          end
        end
      end
      CALC: begin
        state_next = DONE;
      end
      DONE: begin
        if (prod_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  // Datapath: operand capture at the grant edge, one multiply cycle, then the
  // result is held until accepted. prod keeps its value after acceptance.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      rr_ptr     <= '0;
      a_r        <= '0;
      b_r        <= '0;
      id_r       <= '0;
      prod       <= '0;
      prod_id    <= '0;
      prod_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req != '0) begin
            a_r    <= a_bus[int'(win_id) * DATAWIDTH +: DATAWIDTH];
            b_r    <= b_bus[int'(win_id) * DATAWIDTH +: DATAWIDTH];
            id_r   <= win_id;
            rr_ptr <= rr_next;
          end
        end
        CALC: begin
          prod       <= a_r * b_r;
          prod_id    <= id_r;
          prod_valid <= 1'b1;
        end
        DONE: begin
          if (prod_ready) begin
            prod_valid <= 1'b0;
          end
        end
        default: begin
          prod_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter
//   Self-checking bench for mul_share_arbiter. A 64-bit, 4-requester instance
//   is driven with directed and random transactions and compared against a
//   reference model holding only the round-robin pointer; winners and products
//   are derived from the arbitration rule and plain wide arithmetic. A second
//   8-bit, 2-requester instance checks product truncation.
module tb_mul_share_arbiter;

  localparam int DW = 64;
  localparam int N  = 4;
  localparam int IW = 2;

  logic            Clk;
  logic            Rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] a_bus;
  logic [N*DW-1:0] b_bus;
  logic [N-1:0]    gnt;
  logic            busy;
  logic [DW-1:0]   prod;
  logic [IW-1:0]   prod_id;
  logic            prod_valid;
  logic            prod_ready;

  logic [1:0]      req8;
  logic [15:0]     a8;
  logic [15:0]     b8;
  logic [1:0]      gnt8;
  logic            busy8;
  logic [7:0]      prod8;
  logic [0:0]      prod_id8;
  logic            prod_valid8;
  logic            ready8;

  int n_checks = 0;
  int n_fail   = 0;
  int rr_model = 0;

  mul_share_arbiter #(.DATAWIDTH(DW), .NREQ(N), .IDW(IW)) u_dut (
    .Clk(Clk), .Rst(Rst), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .gnt(gnt), .busy(busy), .prod(prod), .prod_id(prod_id),
    .prod_valid(prod_valid), .prod_ready(prod_ready)
  );

  mul_share_arbiter #(.DATAWIDTH(8), .NREQ(2), .IDW(1)) u_dut8 (
    .Clk(Clk), .Rst(Rst), .req(req8), .a_bus(a8), .b_bus(b8),
    .gnt(gnt8), .busy(busy8), .prod(prod8), .prod_id(prod_id8),
    .prod_valid(prod_valid8), .prod_ready(ready8)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First set request at or after ptr, wrapping around the requesters.
  function automatic int pick(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic load_operands();
    for (int i = 0; i < N; i++) begin
      a_bus[i*DW +: DW] = {$urandom, $urandom};
      b_bus[i*DW +: DW] = {$urandom, $urandom};
    end
  endtask

  task automatic apply_reset(input int cycles);
    Rst = 1'b0;
    req = '1;
    prod_ready = 1'b1;
    repeat (cycles) @(posedge Clk);
    #1;
    check("rst_gnt", gnt, '0);
    check("rst_valid", prod_valid, 0);
    check("rst_prod", prod, 0);
    check("rst_busy", busy, 0);
    check("rst_id", prod_id, 0);
    Rst = 1'b0;
    req = '0;
    Rst = 1'b1;
    rr_model = 0;
  endtask

  // One full transaction from IDLE: grant, compute, optional stall, accept.
  task automatic applyStimulus(input logic [N-1:0] mask, input int stall, input string tag);
    int              w;
    logic [N-1:0]    eg;
    logic [DW-1:0]   ea;
    logic [DW-1:0]   eb;
    logic [2*DW-1:0] full;
    logic [DW-1:0]   eprod;
    req = mask;
    prod_ready = (stall == 0);
    #1;
    w = pick(mask, rr_model);
    eg = '0;
    eg[w] = 1'b1;
    ea = a_bus[w*DW +: DW];
    eb = b_bus[w*DW +: DW];
    full = {{DW{1'b0}}, ea} * {{DW{1'b0}}, eb};
    eprod = full[DW-1:0];
    check({tag, "_gnt"}, gnt, eg);
    check({tag, "_idle_busy"}, busy, 0);
    @(posedge Clk); #1;
    rr_model = (w + 1) % N;
    load_operands();
    req = N'($urandom);
    #1;
    check({tag, "_calc_gnt"}, gnt, '0);
    check({tag, "_calc_busy"}, busy, 1);
    check({tag, "_calc_valid"}, prod_valid, 0);
    @(posedge Clk); #1;
    check({tag, "_valid"}, prod_valid, 1);
    check({tag, "_prod"}, prod, eprod);
    check({tag, "_id"}, prod_id, w);
    check({tag, "_done_gnt"}, gnt, '0);
    for (int s = 0; s < stall; s++) begin
      @(posedge Clk); #1;
      check({tag, "_hold_prod"}, prod, eprod);
      check({tag, "_hold_id"}, prod_id, w);
      check({tag, "_hold_valid"}, prod_valid, 1);
      check({tag, "_hold_gnt"}, gnt, '0);
      check({tag, "_hold_busy"}, busy, 1);
    end
    prod_ready = 1'b1;
    @(posedge Clk); #1;
    check({tag, "_accept_valid"}, prod_valid, 0);
    check({tag, "_accept_busy"}, busy, 0);
    check({tag, "_retain_prod"}, prod, eprod);
    req = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check(tag, obs, exp);
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    int w;
    Rst = 1'b0;
    req = '0;
    prod_ready = 1'b1;
    req8 = '0;
    a8 = '0;
    b8 = '0;
    ready8 = 1'b1;
    a_bus = '0;
    b_bus = '0;
    load_operands();

    $display("[TB] reset with all requests raised");
    apply_reset(2);
    applyStimulus('1, 0, "first_after_rst");
    checkOutput("first_after_rst_id0", prod_id, 0);

    $display("[TB] single request 6*7");
    a_bus[0 +: DW] = 64'd6;
    b_bus[0 +: DW] = 64'd7;
    applyStimulus(4'b0001, 0, "single");
    checkOutput("single_42", prod, 64'd42);
    checkOutput("single_id", prod_id, 0);

    $display("[TB] round-robin with all requests held");
    apply_reset(1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus('1, 0, "rr");
      checkOutput("rr_order", prod_id, order[i]);
    end

    $display("[TB] backpressure");
    applyStimulus(4'b0010, 5, "bp");

    $display("[TB] wrap-around and re-request");
    applyStimulus(4'b0100, 0, "to_ptr3");
    applyStimulus(4'b0001, 0, "wrap");
    checkOutput("wrap_id", prod_id, 0);
    applyStimulus('1, 0, "after_wrap");
    checkOutput("after_wrap_id", prod_id, 1);
    applyStimulus(4'b1000, 0, "rereq_a");
    applyStimulus(4'b1000, 0, "rereq_b");
    checkOutput("rereq_id", prod_id, 3);

    $display("[TB] idle cycles leave the pointer alone");
    req = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("idle_gnt", gnt, '0);
      @(posedge Clk); #1;
      checkOutput("idle_busy", busy, 0);
    end
    applyStimulus('1, 0, "post_idle");
    checkOutput("post_idle_id", prod_id, 0);

    $display("[TB] reset during CALC");
    req = 4'b0010;
    #1;
    w = pick(4'b0010, rr_model);
    checkOutput("calc_rst_gnt", gnt, 4'b0010);
    checkOutput("calc_rst_pick", w, 1);
    @(posedge Clk); #1;
    req = '0;
    Rst = 1'b0;
    @(posedge Clk); #1;
    checkOutput("calc_rst_valid", prod_valid, 0);
    checkOutput("calc_rst_busy", busy, 0);
    Rst = 1'b1;
    rr_model = 0;
    @(posedge Clk); #1;
    checkOutput("calc_rst_valid_after", prod_valid, 0);
    applyStimulus('1, 0, "calc_rst_ptr");
    checkOutput("calc_rst_ptr_id", prod_id, 0);

    $display("[TB] random transactions");
    for (int i = 0; i < 30; i++) begin
      load_operands();
      applyStimulus(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 2), "rand");
    end

    $display("[TB] truncation on 8-bit instance");
    req8 = 2'b01;
    a8 = {8'd0, 8'd200};
    b8 = {8'd0, 8'd3};
    #1;
    checkOutput("trunc_gnt", gnt8, 2'b01);
    @(posedge Clk); #1;
    req8 = '0;
    @(posedge Clk); #1;
    checkOutput("trunc_valid", prod_valid8, 1);
    checkOutput("trunc_prod", prod8, 8'h58);
    checkOutput("trunc_id", prod_id8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
